mbikovitsky_lfsr_top: RTL and testbench

//   Tiny Tapeout style top for a 20-bit Fibonacci LFSR with user-loadable taps.
//   All I/O travels over packed 8-bit io_in/io_out buses. The LFSR steps at a

---
 rtl/mbikovitsky_lfsr_pkg.sv | 24 ++
 rtl/mbikovitsky_lfsr_if.sv | 14 +
 rtl/mbikovitsky_lfsr_core.sv | 35 +++
 rtl/mbikovitsky_lfsr_top.sv | 52 +++++
 tb/tb_mbikovitsky_lfsr_top.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mbikovitsky_lfsr_pkg.sv
// Shared constants and the LFSR step function for the 20-bit Fibonacci LFSR.
//   LFSR_W        state / tap mask width
//   CHUNK_W       width of one tap chunk shifted in per load cycle
//   LFSR_SEED     value the state returns to on reset and on lock-up
//   LFSR_MASK_MAX x^20+x^17+1 maximal-length mask (period 2^20-1)
package mbikovitsky_lfsr_pkg;

  localparam int LFSR_W  = 20;
  localparam int CHUNK_W = 5;

  localparam logic [LFSR_W-1:0] LFSR_SEED     = 20'h00001;
  localparam logic [LFSR_W-1:0] LFSR_MASK_MAX = 20'h90000;

  // One Fibonacci step: feedback is the parity of the tapped bits, shifted in
  // at the LSB. An all-zero result would lock the register forever, so it is
  // replaced by the seed.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] t);
    logic [LFSR_W-1:0] n;
    n = {s[LFSR_W-2:0], ^(s & t)};
    return (n == '0) ? LFSR_SEED : n;
  endfunction

endpackage

// File: rtl/mbikovitsky_lfsr_if.sv
// Packed Tiny Tapeout style pin bus.
//   io_in[0]   clk
//   io_in[1]   reset_lfsr
//   io_in[2]   reset_taps
//   io_in[7:3] data_in (tap chunk)
//   io_out     low byte of the LFSR state
// master: the pad/harness side driving io_in; slave: the user design.
interface mbikovitsky_lfsr_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input  io_out);
  modport slave  (input  io_in, output io_out);
endinterface

// File: rtl/mbikovitsky_lfsr_core.sv
// LFSR state, tap mask and step logic.
//   clk        rising-edge clock
//   reset_lfsr sync, active-high: state <= seed (taps untouched)
//   reset_taps sync, active-high: shift data_in into taps, state holds
//   step_en    advance the LFSR this edge (ignored while either reset is high)
//   data_in    tap chunk, MSB chunk first
//   io_byte    state[7:0]
module mbikovitsky_lfsr_core
  import mbikovitsky_lfsr_pkg::*;
(
  input  logic               clk,
  input  logic               reset_lfsr,
  input  logic               reset_taps,
  input  logic               step_en,
  input  logic [CHUNK_W-1:0] data_in,
  output logic [7:0]         io_byte
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] taps;

  // taps has no reset value; it only changes while reset_taps is high, and it
  // still shifts when reset_lfsr is asserted in the same cycle.
  always_ff @(posedge clk) begin
    if (reset_taps) taps <= {taps[LFSR_W-CHUNK_W-1:0], data_in};
  end

  always_ff @(posedge clk) begin
    if (reset_lfsr)                   state <= LFSR_SEED;
    else if (!reset_taps && step_en)  state <= lfsr_next(state, taps);
  end

  assign io_byte = state[7:0];

endmodule

// File: rtl/mbikovitsky_lfsr_top.sv
// Chip-level user design: 20-bit Fibonacci LFSR with loadable taps.
//   bus.io_in[0]   clk
//   bus.io_in[1]   reset_lfsr (sync, active-high)
//   bus.io_in[2]   reset_taps (sync, active-high tap-load enable)
//   bus.io_in[7:3] data_in tap chunk
//   bus.io_out     LFSR state[7:0]
// CLOCK_HZ: clock cycles per LFSR step (>= 1; 1 steps every cycle).
module mbikovitsky_lfsr_top
  import mbikovitsky_lfsr_pkg::*;
#(
  parameter int CLOCK_HZ = 1000
) (
  mbikovitsky_lfsr_if.slave bus
);

  localparam int DIV_W = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLOCK_HZ - 1);

  logic               clk;
  logic               reset_lfsr;
  logic               reset_taps;
  logic [CHUNK_W-1:0] data_in;

  assign clk        = bus.io_in[0];
  assign reset_lfsr = bus.io_in[1];
  assign reset_taps = bus.io_in[2];
  assign data_in    = bus.io_in[7:3];

  // Down-counter; the LFSR steps on the cycle it sits at zero and reloads.
  // A tap load freezes it so the step phase survives reprogramming.
  logic [DIV_W-1:0] div;
  logic             step_en;

  assign step_en = (div == '0) && !reset_lfsr && !reset_taps;

  always_ff @(posedge clk) begin
    if (reset_lfsr)      div <= DIV_RELOAD;
    else if (reset_taps) div <= div;
    else if (div != '0)  div <= div - 1'b1;
    else                 div <= DIV_RELOAD;
  end

  mbikovitsky_lfsr_core u_core (
    .clk        (clk),
    .reset_lfsr (reset_lfsr),
    .reset_taps (reset_taps),
    .step_en    (step_en),
    .data_in    (data_in),
    .io_byte    (bus.io_out)
  );

endmodule

// File: tb/tb_mbikovitsky_lfsr_top.sv
// Directed bench: dut1 runs with CLOCK_HZ=1, dut4 with CLOCK_HZ=4; both see
// the same io_in pins.
module tb_mbikovitsky_lfsr_top;

  logic       clk = 1'b0;
  logic       rl  = 1'b0;
  logic       rt  = 1'b0;
  logic [4:0] din = '0;

  int checks   = 0;
  int failures = 0;

  mbikovitsky_lfsr_if bus1();
  mbikovitsky_lfsr_if bus4();

  assign bus1.io_in = {din, rt, rl, clk};
  assign bus4.io_in = {din, rt, rl, clk};

  mbikovitsky_lfsr_top #(.CLOCK_HZ(1)) dut1 (.bus(bus1));
  mbikovitsky_lfsr_top #(.CLOCK_HZ(4)) dut4 (.bus(bus4));

  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_taps(input logic [19:0] mask);
    rl = 1'b0;
    rt = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      din = mask[i*5 +: 5];
      tick();
    end
    rt  = 1'b0;
    din = '0;
  endtask

  task automatic do_reset();
    rl = 1'b1;
    tick();
    rl = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus1.io_out !== 8'h01) begin
      failures++;
      $display("FAIL reset_out1 got=%h want=01", bus1.io_out);
    end
    checks++;
    if (bus4.io_out !== 8'h01) begin
      failures++;
      $display("FAIL reset_out4 got=%h want=01", bus4.io_out);
    end
  endtask

  task automatic test_tap_load();
    logic [4:0] chunks [4];
    chunks = '{5'h12, 5'h00, 5'h00, 5'h00};
    rt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = chunks[i];
      tick();
      checks++;
      if (bus1.io_out !== 8'h01) begin
        failures++;
        $display("FAIL tapload_hold[%0d] got=%h want=01", i, bus1.io_out);
      end
    end
    rt  = 1'b0;
    din = '0;
    checks++;
    if (dut1.u_core.taps !== 20'h90000) begin
      failures++;
      $display("FAIL tapload_mask got=%h want=90000", dut1.u_core.taps);
    end
  endtask

  task automatic test_reset_keeps_taps();
    tick();
    do_reset();
    checks++;
    if (dut1.u_core.taps !== 20'h90000 || bus1.io_out !== 8'h01) begin
      failures++;
      $display("FAIL reset_keeps_taps taps=%h out=%h want 90000/01",
               dut1.u_core.taps, bus1.io_out);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp [17];
    exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h01};
    do_reset();
    for (int i = 0; i < 17; i++) begin
      tick();
      checks++;
      if (bus1.io_out !== exp[i]) begin
        failures++;
        $display("FAIL seq[%0d] got=%h want=%h", i, bus1.io_out, exp[i]);
      end
    end
    checks++;
    if (dut1.u_core.state !== 20'h20001) begin
      failures++;
      $display("FAIL seq_state got=%h want=20001", dut1.u_core.state);
    end
  endtask

  task automatic test_divider();
    logic [7:0] exp [12];
    exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02,
            8'h04, 8'h04, 8'h04, 8'h04};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (bus4.io_out !== exp[i]) begin
        failures++;
        $display("FAIL div[%0d] got=%h want=%h", i, bus4.io_out, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_guard();
    logic [7:0] exp [20];
    load_taps(20'h00000);
    do_reset();
    for (int i = 0; i < 20; i++)
      exp[i] = (i < 7) ? 8'(1 << (i + 1)) : ((i == 19) ? 8'h01 : 8'h00);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus1.io_out !== exp[i]) begin
        failures++;
        $display("FAIL guard[%0d] got=%h want=%h", i, bus1.io_out, exp[i]);
      end
    end
    checks++;
    if (dut1.u_core.state !== 20'h00001) begin
      failures++;
      $display("FAIL guard_state got=%h want=00001", dut1.u_core.state);
    end
  endtask

  task automatic test_midrun_reset();
    load_taps(20'h90000);
    do_reset();
    repeat (6) tick();
    // dut4 has stepped once (io_out 02) and its divider is mid-count.
    checks++;
    if (bus4.io_out !== 8'h02) begin
      failures++;
      $display("FAIL mid_pre got=%h want=02", bus4.io_out);
    end
    rl  = 1'b1;
    rt  = 1'b1;
    din = 5'h0A;
    tick();
    rl  = 1'b0;
    rt  = 1'b0;
    din = '0;
    checks++;
    if (bus1.io_out !== 8'h01 || bus4.io_out !== 8'h01) begin
      failures++;
      $display("FAIL mid_reset out1=%h out4=%h want 01/01", bus1.io_out, bus4.io_out);
    end
    checks++;
    if (dut4.u_core.taps !== 20'h0000A) begin
      failures++;
      $display("FAIL mid_taps got=%h want=0000a", dut4.u_core.taps);
    end
    // Divider restarted: three holding cycles, then a step.
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus4.io_out !== ((i == 3) ? 8'h02 : 8'h01)) begin
        failures++;
        $display("FAIL mid_div[%0d] got=%h want=%h", i, bus4.io_out,
                 (i == 3) ? 8'h02 : 8'h01);
      end
    end
  endtask

  initial begin
    #1;
    load_taps(20'h90000);
    test_reset();
    test_tap_load();
    test_reset_keeps_taps();
    test_sequence();
    test_divider();
    test_guard();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
